// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM state type and constants for the gated frequency counter
package freq_meter_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, IDLE, GATE, DONE} state_t;
    localparam int LOCK_SETTLE = 16;
    localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser with rising-edge detect on the synchronised value
// Ports: clk, rst_n (sync, active-low), d_async (async input),
//        q_sync (synchronised level), rise (one-cycle pulse on synchronised 0->1)
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_async};
            prev <= q_sync;
        end
    end
    assign q_sync = sync[SYNC_STAGES-1];
    assign rise = q_sync & ~prev;
endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of an async input over a GATE_CYCLES window, qualified by PLL lock
// Ports: clk, rst_n (sync, active-low), pll_locked/sig_in (async), start (1-cycle request),
//        busy (window open), result/overflow (last completed window), result_valid (1-cycle strobe),
//        lock_lost (1-cycle pulse when lock drops outside WAIT_LOCK)
// Build option: FREQ_CONT_EN makes windows run back-to-back after the first start.
module freq_gate_counter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow,
    output logic             lock_lost
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SW = $clog2(LOCK_SETTLE + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t state, state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [GW-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_nxt;
    logic ovf_int, ovf_nxt, locked_s, rise, win_end;
    logic sig_q_unused, lock_rise_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sig (
        .clk(clk), .rst_n(rst_n), .d_async(sig_in), .q_sync(sig_q_unused), .rise(rise)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lock (
        .clk(clk), .rst_n(rst_n), .d_async(pll_locked), .q_sync(locked_s), .rise(lock_rise_unused)
    );

    // Saturating count including this cycle's edge; overflow means an edge arrived at all-ones.
    assign edge_nxt = (rise && edge_cnt != '1) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign ovf_nxt = ovf_int | (rise & (edge_cnt == '1));
    // Lock loss in the last gate cycle wins, so no result is published.
    assign win_end = (state == GATE) && locked_s && (gate_cnt == '0);
    assign busy = (state == GATE);
    assign lock_lost = (state != WAIT_LOCK) && !locked_s;

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: state_nxt = (locked_s && settle_cnt == SW'(LOCK_SETTLE - 1)) ? IDLE : WAIT_LOCK;
            IDLE:      state_nxt = !locked_s ? WAIT_LOCK : (start ? GATE : IDLE);
`ifdef FREQ_CONT_EN
            GATE:      state_nxt = !locked_s ? WAIT_LOCK : GATE;
`else
            GATE:      state_nxt = !locked_s ? WAIT_LOCK : (gate_cnt == '0 ? DONE : GATE);
`endif
            DONE:      state_nxt = !locked_s ? WAIT_LOCK : IDLE;
            default:   state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            settle_cnt <= '0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int <= 1'b0;
            result <= '0;
            overflow <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            settle_cnt <= (state == WAIT_LOCK && locked_s) ? settle_cnt + SW'(1) : '0;
            result_valid <= win_end;
            if (win_end) begin
                result <= edge_nxt;
                overflow <= ovf_nxt;
            end
            if (state == IDLE) begin
                gate_cnt <= GATE_LAST;
                edge_cnt <= '0;
                ovf_int <= 1'b0;
            end else if (state == GATE) begin
                gate_cnt <= (gate_cnt == '0) ? GATE_LAST : gate_cnt - GW'(1);
`ifdef FREQ_CONT_EN
                // Next window starts immediately; the boundary cycle's edge was already counted above.
                edge_cnt <= (gate_cnt == '0) ? '0 : edge_nxt;
                ovf_int <= (gate_cnt == '0) ? 1'b0 : ovf_nxt;
`else
                edge_cnt <= edge_nxt;
                ovf_int <= ovf_nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: randomized self-checking bench for freq_gate_counter (GATE_CYCLES=1000, CNT_W=8)
module tb_freq_gate_counter;
    logic clk, rst_n, pll_locked, sig_in, start;
    logic busy, result_valid, overflow, lock_lost;
    logic [7:0] result;
    int total = 0, bad = 0;
    int acc = 0, snap_res = 0, n_valid = 0, n_lost = 0, busy_cyc = 0, busy_low = 0, cyc = 0, last_valid_cyc = 0;
    bit snap_ovf = 0, busy_q = 0, mon_cont = 0, h0 = 0, h1 = 0, h2 = 0;
    int period = 10, ph = 0;

    freq_gate_counter #(.GATE_CYCLES(1000), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sig_in(sig_in), .start(start),
        .busy(busy), .result(result), .result_valid(result_valid), .overflow(overflow), .lock_lost(lock_lost)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Pin history at each clock edge: an edge sampled between h2 and h1 is counted in the cycle seen now.
    always @(posedge clk) {h2, h1, h0} <= {h1, h0, sig_in};

    // Reference model: accumulate edges over cycles where a window is open, snapshot on each valid.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (result_valid) begin
            snap_res = acc > 255 ? 255 : acc;
            snap_ovf = acc > 255;
            n_valid++;
            last_valid_cyc = cyc;
            acc = 0;
        end
        if (lock_lost) n_lost++;
        if (busy && !busy_q) acc = 0;
        if (busy) begin
            acc += int'(h1 & ~h2);
            busy_cyc++;
        end else if (mon_cont) busy_low++;
        busy_q = busy;
    end

    // Signal under measurement: square wave of given period, or random toggling when period==0.
    initial forever begin
        @(negedge clk);
        if (period == 0) begin
            if ($urandom_range(0, 3) == 0) sig_in = ~sig_in;
        end else begin
            sig_in = (ph < period / 2);
            ph = (ph + 1) % period;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic set_sig(input int p);
        ph = (p > 0) ? int'($urandom_range(0, p - 1)) : 0;
        period = p;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int v0 = n_valid;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (n_valid != v0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic measure(input int p, output bit ok);
        set_sig(p);
        tick(3);
        busy_cyc = 0;
        pulse_start();
        wait_valid(1100, ok);
    endtask

    task automatic test_reset();
        rst_n = 0;
        pll_locked = 1;
        start = 0;
        sig_in = 0;
        tick(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL reset_result got %0d want 0", result); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", result_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got %0b want 0", lock_lost); end
        rst_n = 1;
        tick(30);
    endtask

    task automatic test_single();
        bit ok;
        int v0 = n_valid;
        measure(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got no valid want valid"); end
        total++; if (result !== snap_res[7:0]) begin bad++; $display("FAIL single_model got %0d want %0d", result, snap_res); end
        total++; if (result !== 8'd100) begin bad++; $display("FAIL single_result got %0d want 100", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_overflow got %0b want 0", overflow); end
        tick(10);
        total++; if (busy_cyc != 1000) begin bad++; $display("FAIL single_busy_len got %0d want 1000", busy_cyc); end
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL single_valid_count got %0d want 1", n_valid - v0); end
    endtask

    task automatic test_saturate();
        bit ok;
        measure(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_timeout got no valid want valid"); end
        total++; if (result !== 8'd255) begin bad++; $display("FAIL sat_result got %0d want 255", result); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow got %0b want 1", overflow); end
        total++; if (overflow !== snap_ovf) begin bad++; $display("FAIL sat_model_ovf got %0b want %0b", overflow, snap_ovf); end
        tick(5);
        measure(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL p20_timeout got no valid want valid"); end
        total++; if (result !== 8'd50) begin bad++; $display("FAIL p20_result got %0d want 50", result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL p20_overflow got %0b want 0", overflow); end
        tick(5);
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 4; i++) begin
            measure(($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 40)) : 0, ok);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_timeout got no valid want valid", i); end
            total++; if (result !== snap_res[7:0]) begin bad++; $display("FAIL rand%0d_result got %0d want %0d", i, result, snap_res); end
            total++; if (overflow !== snap_ovf) begin bad++; $display("FAIL rand%0d_overflow got %0b want %0b", i, overflow, snap_ovf); end
            tick(5);
        end
    endtask

    task automatic test_lock_loss();
        bit ok;
        logic [7:0] prev;
        int pv, nl, lat;
        set_sig(10);
        tick(3);
        pulse_start();
        tick(300);
        prev = result;
        pv = n_valid;
        nl = n_lost;
        pll_locked = 0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            lat++;
            if (n_lost != nl) break;
        end
        total++; if (lat != 2) begin bad++; $display("FAIL lost_latency got %0d want 2", lat); end
        tick(20);
        total++; if (n_lost - nl != 1) begin bad++; $display("FAIL lost_pulses got %0d want 1", n_lost - nl); end
        total++; if (n_valid != pv) begin bad++; $display("FAIL lost_no_valid got %0d want %0d", n_valid, pv); end
        total++; if (result !== prev) begin bad++; $display("FAIL lost_result_held got %0d want %0d", result, prev); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lost_busy got %0b want 0", busy); end
        pll_locked = 1;
        tick(8);
        pulse_start();
        tick(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL resettle_early_start got busy=%0b want 0", busy); end
        tick(30);
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL resettle_start got busy=%0b want 1", busy); end
        wait_valid(1100, ok);
        total++; if (!ok || result !== snap_res[7:0]) begin bad++; $display("FAIL resettle_result got %0d want %0d (valid seen=%0b)", result, snap_res, ok); end
        tick(5);
    endtask

    task automatic test_ignored_start();
        bit ok;
        int v0 = n_valid;
        set_sig(20);
        tick(3);
        busy_cyc = 0;
        pulse_start();
        tick(500);
        pulse_start();
        wait_valid(1100, ok);
        pulse_start();
        tick(1200);
        total++; if (!ok) begin bad++; $display("FAIL ign_timeout got no valid want valid"); end
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL ign_valid_count got %0d want 1", n_valid - v0); end
        total++; if (busy_cyc != 1000) begin bad++; $display("FAIL ign_busy_len got %0d want 1000", busy_cyc); end
        total++; if (result !== 8'd50) begin bad++; $display("FAIL ign_result got %0d want 50", result); end
    endtask

    task automatic test_reset_mid();
        int nv, nl;
        set_sig(10);
        tick(3);
        pulse_start();
        tick(200);
        rst_n = 0;
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL rstmid_result got %0d want 0", result); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %0b want 0", result_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got %0b want 0", overflow); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL rstmid_lock_lost got %0b want 0", lock_lost); end
        pll_locked = 0;
        rst_n = 1;
        nv = n_valid;
        nl = n_lost;
        busy_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            pll_locked = 1;
            tick(5);
            pulse_start();
            tick(4);
            pll_locked = 0;
            tick(6);
        end
        total++; if (busy_cyc != 0) begin bad++; $display("FAIL short_lock_busy got %0d want 0", busy_cyc); end
        total++; if (n_valid != nv) begin bad++; $display("FAIL short_lock_valid got %0d want %0d", n_valid, nv); end
        total++; if (n_lost != nl) begin bad++; $display("FAIL short_lock_lost got %0d want %0d", n_lost, nl); end
        pll_locked = 1;
        tick(30);
    endtask

    task automatic test_continuous();
        bit ok;
        int prev_cyc = 0, nl;
        set_sig(10);
        tick(3);
        busy_low = 0;
        pulse_start();
        mon_cont = 1;
        for (int w = 0; w < 6; w++) begin
            if (w == 3) set_sig(7);
            wait_valid(1100, ok);
            total++; if (!ok) begin bad++; $display("FAIL cont%0d_timeout got no valid want valid", w); end
            total++; if (result !== snap_res[7:0]) begin bad++; $display("FAIL cont%0d_result got %0d want %0d", w, result, snap_res); end
            if (w < 3) begin
                total++; if (result !== 8'd100) begin bad++; $display("FAIL cont%0d_p10 got %0d want 100", w, result); end
            end
            if (w > 0) begin
                total++; if (last_valid_cyc - prev_cyc != 1000) begin bad++; $display("FAIL cont%0d_spacing got %0d want 1000", w, last_valid_cyc - prev_cyc); end
            end
            prev_cyc = last_valid_cyc;
        end
        mon_cont = 0;
        total++; if (busy_low != 0) begin bad++; $display("FAIL cont_busy_drop got %0d want 0", busy_low); end
        nl = n_lost;
        pll_locked = 0;
        tick(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got %0b want 0", busy); end
        total++; if (n_lost - nl != 1) begin bad++; $display("FAIL cont_stop_lost got %0d want 1", n_lost - nl); end
        pll_locked = 1;
        tick(30);
    endtask

    initial begin
        test_reset();
`ifdef FREQ_CONT_EN
        test_continuous();
        test_reset_mid();
`else
        test_single();
        test_saturate();
        test_random();
        test_lock_loss();
        test_ignored_start();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
